barret_743_sched: RTL and testbench



---
 rtl/barret_743_pkg.sv | 32 +++
 rtl/barret_743_pipe.sv | 74 +++++++
 rtl/barret_743_sched.sv | 109 ++++++++++
 tb/tb_barret_743_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/barret_743_pkg.sv
// Shared constants and arithmetic helpers for the mod-743 Barrett scheduler.
// The quotient estimate and the final fold live here so the pipeline stages
// stay small.
package barret_743_pkg;

    localparam int BARRET_Q  = 743;
    localparam int BARRET_MU = 1411;
    localparam int BARRET_K  = 10;
    localparam int DIN_W     = 19;
    localparam int DOUT_W    = 10;
    localparam int R_W       = 12;

    // Quotient estimate t = ((a >> K) * MU) >> K; the product fits in 20 bits.
    function automatic logic [DOUT_W-1:0] barret_quot(input logic [DIN_W-1:0] a);
        logic [19:0] prod;
        prod = 20'(a >> BARRET_K) * 20'(BARRET_MU);
        return DOUT_W'(prod >> BARRET_K);
    endfunction

    // r = a - t*Q lies in [0, 3Q), so two conditional subtractions fully reduce it.
    function automatic logic [DOUT_W-1:0] barret_fold(input logic [DIN_W-1:0] a,
                                                      input logic [DOUT_W-1:0] t);
        logic [R_W-1:0] r;
        logic [R_W-1:0] r1;
        logic [R_W-1:0] r2;
        r  = R_W'(20'(a) - 20'(t) * 20'(BARRET_Q));
        r1 = (r  >= R_W'(BARRET_Q)) ? r  - R_W'(BARRET_Q) : r;
        r2 = (r1 >= R_W'(BARRET_Q)) ? r1 - R_W'(BARRET_Q) : r1;
        return DOUT_W'(r2);
    endfunction

endpackage

// File: rtl/barret_743_pipe.sv
// Two-stage elastic Barrett mod-743 datapath. S1 holds the operand and its
// quotient estimate, S2 holds the fully reduced residue. Both stages can
// advance in the same cycle, so a full pipe streams one result per cycle.
module barret_743_pipe
    import barret_743_pkg::*;
#(
    parameter int TAG_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIN_W-1:0]  in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DOUT_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    logic              s1_v_reg;
    logic [DIN_W-1:0]  s1_a_reg;
    logic [DOUT_W-1:0] s1_t_reg;
    logic [TAG_W-1:0]  s1_tag_reg;
    logic              s2_v_reg;
    logic [DOUT_W-1:0] s2_data_reg;
    logic [TAG_W-1:0]  s2_tag_reg;
    logic              adv_s2;
    logic              load_s1;

    assign adv_s2  = !s2_v_reg | out_ready;
    assign load_s1 = !s1_v_reg | adv_s2;
    // Held low during reset so no requester sees an accept while flushing.
    assign in_ready = load_s1 & rst_n;

    assign out_valid = s2_v_reg;
    assign out_data  = s2_data_reg;
    assign out_tag   = s2_tag_reg;
    assign busy      = s1_v_reg | s2_v_reg;

    // Stage 1: capture operand, tag and quotient estimate whenever S1 can load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_reg   <= 1'b0;
            s1_a_reg   <= '0;
            s1_t_reg   <= '0;
            s1_tag_reg <= '0;
        end else if (load_s1) begin
            s1_v_reg <= in_valid;
            if (in_valid) begin
                s1_a_reg   <= in_data;
                s1_t_reg   <= barret_quot(in_data);
                s1_tag_reg <= in_tag;
            end
        end
    end

    // Stage 2: fold to the final residue; contents hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_reg    <= 1'b0;
            s2_data_reg <= '0;
            s2_tag_reg  <= '0;
        end else if (adv_s2) begin
            s2_v_reg <= s1_v_reg;
            if (s1_v_reg) begin
                s2_data_reg <= barret_fold(s1_a_reg, s1_t_reg);
                s2_tag_reg  <= s1_tag_reg;
            end
        end
    end

endmodule

// File: rtl/barret_743_sched.sv
// Scheduler sharing one mod-743 Barrett pipeline among N_REQ requesters.
// Optional feature macro: BARRET_743_RR_EN selects round-robin arbitration;
// without it the lowest valid index always wins.
module barret_743_sched
    import barret_743_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int TAG_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*DIN_W-1:0] req_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DOUT_W-1:0]      out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   busy
);

    logic [N_REQ-1:0] grant;
    logic [TAG_W-1:0] grant_idx;
    logic [DIN_W-1:0] grant_data;
    logic             pipe_ready;

`ifdef BARRET_743_RR_EN
    localparam int PW = TAG_W + 1;
    logic [TAG_W-1:0] rr_ptr_reg;

    // Search from rr_ptr upward with wrap; descending loop lets the nearest index win.
    always_comb begin
        logic [PW-1:0]    sum;
        logic [TAG_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        sum       = '0;
        idx       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_reg} + PW'(k);
            if (sum >= PW'(N_REQ)) begin
                sum = sum - PW'(N_REQ);
            end
            idx = sum[TAG_W-1:0];
            if (req_valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    // Pointer moves just past the requester that actually transferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
        end else if ((|grant) && pipe_ready) begin
            rr_ptr_reg <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + TAG_W'(1);
        end
    end
`else
    // Fixed priority: lowest valid index wins, no history kept.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                grant     = '0;
                grant[k]  = 1'b1;
                grant_idx = TAG_W'(k);
            end
        end
    end
`endif

    // Operand mux driven by the one-hot grant.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                grant_data = req_data[k*DIN_W +: DIN_W];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant[gi] & pipe_ready;
        end
    endgenerate

    barret_743_pipe #(
        .TAG_W(TAG_W)
    ) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (|grant),
        .in_ready (pipe_ready),
        .in_data  (grant_data),
        .in_tag   (grant_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag),
        .busy     (busy)
    );

endmodule

// File: tb/tb_barret_743_sched.sv
// Self-checking bench for barret_743_sched: directed vector table, fairness,
// backpressure, reset and wrap sequences, then randomized traffic against a
// queue-based reference model.
module tb_barret_743_sched;

    localparam int N_REQ = 4;
    localparam int TAG_W = 2;
    localparam int Q     = 743;
    localparam int N_RAND = 2000;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*19-1:0] req_data;
    logic                out_valid;
    logic                out_ready;
    logic [9:0]          out_data;
    logic [TAG_W-1:0]    out_tag;
    logic                busy;

    barret_743_sched #(.N_REQ(N_REQ)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data (req_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int op;
        int acc;
    } entry_t;

    typedef struct {
        logic [18:0] op;
        logic [9:0]  exp;
    } vec_t;

    entry_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int model_ptr = 0;
    int n_acc = 0;
    int n_out = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // First valid requester at or after ptr, wrapping.
    function automatic logic [3:0] model_grant(input logic [3:0] v, input int ptr);
        for (int k = 0; k < N_REQ; k++) begin
            int i;
            i = (ptr + k) % N_REQ;
            if (v[i]) return 4'(1 << i);
        end
        return 4'b0;
    endfunction

    // Called just after a negedge once inputs are set; checks, updates model, moves to next negedge.
    task automatic cycle_eval();
        logic [3:0] exp_ready;
        logic [3:0] acc_bits;
        logic       exp_valid;
        int         idx;
        #1;
        exp_ready = (q.size() < 2 || out_ready) ? model_grant(req_valid, model_ptr) : 4'b0;
        check("req_ready", req_ready, exp_ready);
        exp_valid = (q.size() > 0) && (cyc >= q[0].acc + 2);
        check("out_valid", out_valid, exp_valid);
        check("busy", busy, q.size() > 0);
        if (exp_valid) begin
            check("out_data", out_data, q[0].op % Q);
            check("out_tag", out_tag, q[0].tag);
            if (out_ready) begin
                $display("OUT cyc=%0d tag=%0d op=%0d data=%0d", cyc, out_tag, q[0].op, out_data);
                void'(q.pop_front());
                n_out++;
            end
        end
        acc_bits = req_valid & req_ready;
        if (acc_bits != 4'b0) begin
            idx = 0;
            for (int k = N_REQ - 1; k >= 0; k--) begin
                if (acc_bits[k]) idx = k;
            end
            q.push_back('{tag: idx, op: int'(req_data[idx*19 +: 19]), acc: cyc});
            n_acc++;
`ifdef BARRET_743_RR_EN
            model_ptr = (idx + 1) % N_REQ;
`endif
            $display("IN  cyc=%0d tag=%0d op=%0d", cyc, idx, req_data[idx*19 +: 19]);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        q.delete();
        model_ptr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        out_ready = 1'b1;
        repeat (n) cycle_eval();
    endtask

    initial begin
        vec_t tbl[6];
        logic [3:0]  fair_exp;
        logic [9:0]  held_data;
        logic [1:0]  held_tag;
        int          acc_before;

        tbl[0] = '{op: 19'd0,      exp: 10'd0};
        tbl[1] = '{op: 19'd742,    exp: 10'd742};
        tbl[2] = '{op: 19'd743,    exp: 10'd0};
        tbl[3] = '{op: 19'd1486,   exp: 10'd0};
        tbl[4] = '{op: 19'd100000, exp: 10'd438};
        tbl[5] = '{op: 19'd524287, exp: 10'd472};
        held_data = '0;
        held_tag  = '0;

        // Reset state, with requests pending so req_ready gating is exercised.
        rst_n = 1'b0;
        req_data = '0;
        req_valid = '0;
        out_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        check("rst_req_ready", req_ready, 4'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 10'd0);
        check("rst_out_tag", out_tag, 2'd0);
        check("rst_busy", busy, 1'b0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table from requester 0, each result two cycles after its accept.
        for (int i = 0; i < 6; i++) begin
            req_data = '0;
            req_data[18:0] = tbl[i].op;
            req_valid = 4'b0001;
            out_ready = 1'b1;
            cycle_eval();
            req_valid = '0;
            cycle_eval();
            #1;
            check("vec_valid", out_valid, 1'b1);
            check("vec_data", out_data, tbl[i].exp);
            check("vec_tag", out_tag, 2'd0);
            cycle_eval();
        end

        // Fairness: all requesters valid, consumer always ready.
        do_reset();
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < N_REQ; k++) req_data[k*19 +: 19] = 19'($urandom);
`ifdef BARRET_743_RR_EN
            fair_exp = 4'(1 << (i % N_REQ));
`else
            fair_exp = 4'b0001;
`endif
            #1;
            check("fair_grant", req_ready, fair_exp);
            if (i >= 2) check("fair_rate", out_valid, 1'b1);
            cycle_eval();
        end
        drain(3);

        // Backpressure: requester 2 streams into a stalled output.
        acc_before = n_acc;
        req_valid = 4'b0100;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < N_REQ; k++) req_data[k*19 +: 19] = 19'($urandom);
            if (i == 2) begin
                #1;
                held_data = out_data;
                held_tag  = out_tag;
            end else if (i > 2) begin
                #1;
                check("bp_hold_data", out_data, held_data);
                check("bp_hold_tag", out_tag, held_tag);
            end
            cycle_eval();
        end
        check("bp_accepts", n_acc - acc_before, 2);
        drain(3);
        check("bp_drained", q.size(), 0);

        // Pointer wrap: 0 transfers, then 3 alone, then pointer back at 0.
        do_reset();
        req_data = '0;
        req_data[0*19 +: 19] = 19'd1000;
        req_data[3*19 +: 19] = 19'd3000;
        req_valid = 4'b0001;
        cycle_eval();
        req_valid = 4'b1000;
        #1;
        check("wrap_grant3", req_ready, 4'b1000);
        cycle_eval();
        req_valid = 4'b1001;
        #1;
        check("wrap_ptr0", req_ready, 4'b0001);
        cycle_eval();
        cycle_eval();
        drain(3);

        // Asynchronous reset with two entries in flight.
        req_valid = 4'b0100;
        out_ready = 1'b0;
        cycle_eval();
        cycle_eval();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_req_ready", req_ready, 4'b0);
        q.delete();
        model_ptr = 0;
        req_valid = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req_data[1*19 +: 19] = 19'd12345;
        req_valid = 4'b0010;
        cycle_eval();
        drain(3);
        check("post_rst_empty", q.size(), 0);

        // Randomized traffic against the queue model.
        for (int n = 0; n < N_RAND; n++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int k = 0; k < N_REQ; k++) req_data[k*19 +: 19] = 19'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle_eval();
        end
        drain(4);
        check("rand_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
